// File: rtl/restock_scheduler.sv
// Serializes purchases and owner restock charges onto the single-port supply array.
// Define RESTOCK_CLAMP_EN to saturate an overflowing charge at 15 instead of skipping the write.
module restock_scheduler #(
  parameter int NUM_SLOTS = 4,
  parameter int SW        = $clog2(NUM_SLOTS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    mode,
  input  logic          buy_req,
  input  logic [SW-1:0] buy_slot,
  output logic          buy_ack,
  output logic          buy_empty,
  input  logic          chg_req,
  input  logic [SW-1:0] chg_slot,
  input  logic [3:0]    chg_amount,
  output logic          chg_ack,
  output logic          chg_reject,
  output logic [SW-1:0] arr_addr,
  input  logic [3:0]    arr_rd_data,
  output logic          arr_wr_en,
  output logic [3:0]    arr_wr_data,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  logic          r_op_buy;
  logic          r_last_chg;
  logic          r_flag_q;
  logic [3:0]    r_amt_q;

  logic          w_buy_elig;
  logic          w_chg_elig;
  logic          w_grant;
  logic          w_grant_buy;
  logic [SW-1:0] w_grant_slot;
  logic [4:0]    w_sum;
  logic [3:0]    w_res;
  logic          w_we;
  logic          w_flag;

  // Mode gating and round-robin choice between the two requesters.
  always_comb begin
    w_buy_elig  = buy_req && ((mode == 2'b01) || (mode == 2'b11));
    w_chg_elig  = chg_req && ((mode == 2'b10) || (mode == 2'b11));
    w_grant     = w_buy_elig || w_chg_elig;
    w_grant_buy = w_buy_elig && (!w_chg_elig || r_last_chg);
    if (w_grant_buy) begin
      w_grant_slot = buy_slot;
    end else begin
      w_grant_slot = chg_slot;
    end
  end

  // Read-modify-write arithmetic evaluated while the array read is valid.
  always_comb begin
    w_sum  = {1'b0, arr_rd_data} + {1'b0, r_amt_q};
    w_res  = 4'd0;
    w_we   = 1'b0;
    w_flag = 1'b0;
    if (r_op_buy) begin
      if (arr_rd_data == 4'd0) begin
        w_flag = 1'b1;
      end else begin
        w_res = arr_rd_data - 4'd1;
        w_we  = 1'b1;
      end
    end else if (w_sum > 5'd15) begin
      w_flag = 1'b1;
`ifdef RESTOCK_CLAMP_EN
      w_res  = 4'd15;
      w_we   = 1'b1;
`else
      w_res  = arr_rd_data;
      w_we   = 1'b0;
`endif
    end else begin
      w_res = w_sum[3:0];
      w_we  = 1'b1;
    end
  end

  // Transaction sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op_buy    <= 1'b0;
      r_last_chg  <= 1'b1;
      r_flag_q    <= 1'b0;
      r_amt_q     <= 4'd0;
      buy_ack     <= 1'b0;
      buy_empty   <= 1'b0;
      chg_ack     <= 1'b0;
      chg_reject  <= 1'b0;
      arr_addr    <= '0;
      arr_wr_en   <= 1'b0;
      arr_wr_data <= 4'd0;
      busy        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_op_buy   <= w_grant_buy;
            r_last_chg <= !w_grant_buy;
            r_amt_q    <= chg_amount;
            arr_addr   <= w_grant_slot;
            busy       <= 1'b1;
            r_state    <= S_READ;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_READ: begin
          r_flag_q  <= w_flag;
          arr_wr_en <= w_we;
          if (w_we) begin
            arr_wr_data <= w_res;
          end else begin
            arr_wr_data <= arr_wr_data;
          end
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          arr_wr_en <= 1'b0;
          buy_ack   <= r_op_buy;
          chg_ack   <= !r_op_buy;
          buy_empty <= r_op_buy && r_flag_q;
          // The red light only follows charges; purchases leave it alone.
          if (!r_op_buy) begin
            chg_reject <= r_flag_q;
          end else begin
            chg_reject <= chg_reject;
          end
          r_state <= S_DONE;
        end
        S_DONE: begin
          buy_ack   <= 1'b0;
          chg_ack   <= 1'b0;
          buy_empty <= 1'b0;
          busy      <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          buy_ack   <= 1'b0;
          chg_ack   <= 1'b0;
          buy_empty <= 1'b0;
          arr_wr_en <= 1'b0;
          busy      <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
